// File: rtl/simon_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : simon_key_expander
// Purpose  : Sequential SIMON key-expansion engine. Loads an M-word master
//            key and streams round keys k[0]..k[T-1], one per valid/ready
//            handshake. Works for any SIMON word size N, key-word count
//            M (2/3/4), round count T and z constant sequence.
// Ports    : clk       - clock
//            rst_n     - asynchronous active-low reset
//            start     - load key_in and begin expansion (only in IDLE)
//            key_in    - master key, word w at bits [w*N +: N] is k[w]
//            busy      - high while keys are being emitted
//            rk_valid  - rk_data / rk_index valid
//            rk_ready  - consumer accepts the current key
//            rk_data   - round key k[rk_index]
//            rk_index  - index of the current key, 0..T-1
//            done      - one-cycle pulse after the final key handshake
//            rd_addr   - (SIMON_KS_STORE_EN) key-store read address
//            rd_data   - (SIMON_KS_STORE_EN) registered key-store read data
// Options  : define SIMON_KS_STORE_EN to add a T x N key store that captures
//            every handshaked key, readable through rd_addr / rd_data.
// Revision : 1.0 - initial release
// ============================================================================
module simon_key_expander #(
    parameter int          N     = 32,
    parameter int          M     = 3,
    parameter int          T     = 42,
    // z2, LSB = z[0]
    parameter logic [61:0] Z_SEQ = 62'b11_0011011010_0111111000_1000010100_0110010010_1100000011_1011110101,
    parameter int          IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [M*N-1:0]   key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [N-1:0]     rk_data,
    output logic [IDX_W-1:0] rk_index,
    output logic             done
`ifdef SIMON_KS_STORE_EN
    ,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [N-1:0]     rd_data
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time legality checks
    // ------------------------------------------------------------------------
    if (M < 2 || M > 4) begin : g_badM
        $error("simon_key_expander: M must be 2, 3 or 4");
    end
    if (T <= M) begin : g_badT
        $error("simon_key_expander: T must be greater than M");
    end
    if (T > (1 << IDX_W)) begin : g_badIdxW
        $error("simon_key_expander: IDX_W too narrow for T");
    end
    if (N != 16 && N != 24 && N != 32 && N != 48 && N != 64) begin : g_badN
        $error("simon_key_expander: N must be 16, 24, 32, 48 or 64");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]       c_IDLE     = 2'd0;
    localparam logic [1:0]       c_EMIT     = 2'd1;
    localparam logic [1:0]       c_FIN      = 2'd2;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(T - 1);
    localparam logic [5:0]       c_Z_LAST   = 6'd61;
    localparam logic [N-1:0]     c_THREE    = N'(3);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_stateNext;
    logic [N-1:0]     r_window [M];
    logic [5:0]       r_zPtr;
    logic [IDX_W-1:0] r_idx;

    logic             w_load;
    logic             w_advance;
    logic [N-1:0]     w_keyWord [M];
    logic [N-1:0]     w_rot3;
    logic [N-1:0]     w_tmp;
    logic [N-1:0]     w_zExt;
    logic [N-1:0]     w_newWord;

    // ------------------------------------------------------------------------
    // Master-key unpacking
    // ------------------------------------------------------------------------
    for (genvar gw = 0; gw < M; gw++) begin : g_keyWord
        assign w_keyWord[gw] = key_in[gw*N +: N];
    end

    // ------------------------------------------------------------------------
    // New-word generation: k[i+M] from the window k[i]..k[i+M-1].
    // ~window[0] ^ 3 folds the constant c = 2^N-4 into a single inversion.
    // ------------------------------------------------------------------------
    assign w_rot3 = {r_window[M-1][2:0], r_window[M-1][N-1:3]};

    if (M == 4) begin : g_fourWord
        assign w_tmp = w_rot3 ^ r_window[1];
    end else begin : g_fewWord
        assign w_tmp = w_rot3;
    end

    assign w_zExt    = {{(N-1){1'b0}}, Z_SEQ[r_zPtr]};
    assign w_newWord = ~r_window[0] ^ w_tmp ^ {w_tmp[0], w_tmp[N-1:1]} ^ c_THREE ^ w_zExt;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        busy        = 1'b0;
        rk_valid    = 1'b0;
        rk_data     = '0;
        rk_index    = '0;
        done        = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_stateNext = c_EMIT;
                end
            end
            c_EMIT: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                rk_data  = r_window[0];
                rk_index = r_idx;
                if (rk_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_stateNext = c_FIN;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            c_FIN: begin
                // start is deliberately not looked at here
                done        = 1'b1;
                w_stateNext = c_IDLE;
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Key window, z pointer and index. Everything holds unless a load or a
    // non-final handshake occurs, which gives stable outputs under stalls.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < M; w++) begin
                r_window[w] <= '0;
            end
            r_zPtr <= '0;
            r_idx  <= '0;
        end else if (w_load) begin
            for (int w = 0; w < M; w++) begin
                r_window[w] <= w_keyWord[w];
            end
            r_zPtr <= '0;
            r_idx  <= '0;
        end else if (w_advance) begin
            for (int w = 0; w < M - 1; w++) begin
                r_window[w] <= r_window[w+1];
            end
            r_window[M-1] <= w_newWord;
            r_zPtr        <= (r_zPtr == c_Z_LAST) ? 6'd0 : r_zPtr + 6'd1;
            r_idx         <= r_idx + IDX_W'(1);
        end
    end

`ifdef SIMON_KS_STORE_EN
    // ------------------------------------------------------------------------
    // Optional key store. The array has no reset so that its contents stay
    // available after done; only the read register is cleared.
    // ------------------------------------------------------------------------
    localparam int                c_ADDR_W = $clog2(T);
    localparam logic [IDX_W-1:0]  c_DEPTH  = IDX_W'(T);

    logic [N-1:0]        r_store [T];
    logic [N-1:0]        r_rdData;
    logic [c_ADDR_W-1:0] w_wrAddr;
    logic [c_ADDR_W-1:0] w_rdAddr;

    assign w_wrAddr = r_idx[c_ADDR_W-1:0];
    assign w_rdAddr = rd_addr[c_ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rk_valid && rk_ready) begin
            r_store[w_wrAddr] <= r_window[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData <= '0;
        end else begin
            // out-of-range addresses read as zero
            r_rdData <= (rd_addr < c_DEPTH) ? r_store[w_rdAddr] : '0;
        end
    end

    assign rd_data = r_rdData;
`endif

endmodule
`default_nettype wire
